mci_mcu_sram_ctrl: RTL and testbench
====================================

Name: mci_mcu_sram_ctrl

Overview:
- Target-side controller for the MCU SRAM; consumes the CIF request stream the MCI AXI decoder steers to the SRAM.
- Drives a single-port 1-cycle-latency SRAM macro: 32-bit data plus 7-bit SECDED.
- Converts partial-strobe writes into read-modify-write sequences.
- Generates hold/error back toward the decoder; reports ECC events to MCI status logic.

Parameters:
- SRAM_SIZE_KB, 512, SRAM capacity in KB; power of two.
- ADDR_WIDTH, 32, request byte-address width; address is an offset already base-stripped by the decoder.
- DATA_WIDTH, 32, data width; only 32 supported, elaboration error otherwise.
- ECC_WIDTH, 7, SECDED check bits.
- SRAM_AW, $clog2(SRAM_SIZE_KB*256), derived word-index width; localparam.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_dv  in  1  request valid; held with req fields stable while req_hold=1
- req_addr  in  ADDR_WIDTH  byte address
- req_write  in  1  1=write, 0=read
- req_wdata  in  32  write data
- req_wstrb  in  4  byte strobes
- req_hold  out  1  stall; transaction completes in cycle with req_dv=1 and req_hold=0
- req_rdata  out  32  read data; valid in completion cycle
- req_error  out  1  error response; valid in completion cycle
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  SRAM_AW  word index
- sram_wdata  out  39  {ecc[6:0], data[31:0]}
- sram_rdata  in  39  read data, valid cycle after cs with we=0
- ecc_sbe_pulse  out  1  one-cycle pulse: corrected single-bit error
- ecc_dbe_pulse  out  1  one-cycle pulse: uncorrectable double-bit error
- sbe_count  out  16  saturating corrected-error count
- sbe_count_clr  in  1  clears sbe_count

Behaviour:
- Reset: state=IDLE; sbe_count=0. All outputs 0: req_hold, req_rdata, req_error, sram_*, pulses.
- Word index = req_addr[SRAM_AW+1:2]; addr[1:0] ignored.
- Out of range (req_addr >= SRAM_SIZE_KB*1024): IDLE completes same cycle with hold=0, error=1, rdata=0, no SRAM access.
- FSM states: IDLE, RD_WAIT, RMW_RD, RMW_WR.
- IDLE, read in range: hold=1, cs=1, we=0; goto RD_WAIT.
- RD_WAIT:
  - Decode sram_rdata; hold=0; rdata=corrected data; goto IDLE.
  - SBE: error=0, ecc_sbe_pulse=1.
  - DBE: error=1, rdata=raw data bits, ecc_dbe_pulse=1.
  - Read latency: 2 cycles.
- IDLE, write, wstrb=4'hF: hold=0, cs=1, we=1, wdata=encode(req_wdata); completes same cycle.
- IDLE, write, wstrb=0: completes same cycle, hold=0, error=0, no SRAM access.
- IDLE, write, partial strobe: hold=1, cs=1, we=0; goto RMW_RD.
- RMW_RD: decode old word.
  - No DBE: merge byte-wise (strobed bytes from req_wdata, rest from corrected old); cs=1, we=1, encoded merge; hold=0; goto IDLE.
  - DBE: no write, hold=0, error=1, dbe pulse; goto IDLE.
  - SBE during RMW: sbe pulse, corrected merge written (scrubs).
- RMW_WR: reserved encoding; unreachable, returns to IDLE. Partial write therefore completes in 2 cycles.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after completion; no bubble required beyond the FSM return.
- req_dv dropping while hold=1 is a protocol violation; assertion only, FSM still finishes its SRAM access.
- sbe_count: +1 per SBE, saturates at 16'hFFFF.
  - sbe_count_clr alone: count→0.
  - clr and SBE in same cycle: count→1.
- Reset mid-operation: FSM→IDLE next edge, pending RMW write is dropped, hold=0.

Decomposition:
- Shared package mci_sram_pkg:
  - SECDED(39,32) H-matrix constants.
  - ECC_WIDTH.
  - FSM state enum.
  - ecc_status_t {sbe, dbe, syndrome}.
- Sub-module mci_secded_39_32: combinational encode and decode/correct; instantiated once for write path, once for read path.

Test Plan:
- Read addr 0x10 after backdoor-loading word 4 with encode(0xDEADBEEF) -> hold=1 one cycle, then rdata=0xDEADBEEF, error=0; total 2 cycles.
- Full write 0x12345678 to 0x20, wstrb=F -> completes cycle 0, sram_addr=8, we=1, sram_wdata=encode(0x12345678).
- Partial write wstrb=4'b0010, wdata=0x0000AB00 onto stored 0x11223344 -> SRAM read, then write encode(0x1122AB44); hold high exactly 1 cycle.
- Flip data bit 5 of stored word, read -> corrected data returned, error=0, sbe pulse, sbe_count=1; same-cycle clr+SBE -> count=1.
- Flip bits 3 and 9, read -> error=1, dbe pulse; same flips then partial write -> error=1, no SRAM write observed.
- Address SRAM_SIZE_KB*1024 -> same-cycle error=1, sram_cs never asserted; assert rst during RMW_RD -> no write issued, hold=0.

Source files
------------

// File: rtl/mci_sram_pkg.sv
// Purpose: shared types and SECDED(39,32) code definition for the MCU SRAM controller.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package mci_sram_pkg;

    localparam int SECDED_DATA_W = 32;
    localparam int ECC_WIDTH     = 7;
    localparam int SECDED_CODE_W = SECDED_DATA_W + ECC_WIDTH;

    // Hsiao-style H-matrix: one column per data bit.
    // All columns are distinct weight-3 vectors and the check-bit columns are weight-1.
    // So a single error always leaves an odd-weight syndrome that matches exactly one
    // column. A double error leaves a non-zero even-weight syndrome that matches none.
    // Columns are the first 32 weight-3 vectors in lexicographic order of
    // their set-bit positions.
    localparam logic [ECC_WIDTH-1:0] H_COL [SECDED_DATA_W] = '{
        7'h07, 7'h0B, 7'h13, 7'h23, 7'h43, 7'h0D, 7'h15, 7'h25,
        7'h45, 7'h19, 7'h29, 7'h49, 7'h31, 7'h51, 7'h61, 7'h0E,
        7'h16, 7'h26, 7'h46, 7'h1A, 7'h2A, 7'h4A, 7'h32, 7'h52,
        7'h62, 7'h1C, 7'h2C, 7'h4C, 7'h34, 7'h54, 7'h64, 7'h38
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_RD  = 2'd2,
        RMW_WR  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic                 sbe;
        logic                 dbe;
        logic [ECC_WIDTH-1:0] syndrome;
    } ecc_status_t;

    // Check bits for a data word: XOR of the H columns of every set data bit.
    function automatic logic [ECC_WIDTH-1:0] secded_check(input logic [SECDED_DATA_W-1:0] data);
        logic [ECC_WIDTH-1:0] chk;
        chk = '0;
        for (int i = 0; i < SECDED_DATA_W; i++) begin
            if (data[i]) chk ^= H_COL[i];
        end
        return chk;
    endfunction

endpackage

// File: rtl/mci_secded_39_32.sv
// Purpose: SECDED(39,32) encoder plus decoder/corrector.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; no state or handshake.
module mci_secded_39_32
    import mci_sram_pkg::*;
(
    input  logic [SECDED_DATA_W-1:0] enc_data,
    output logic [ECC_WIDTH-1:0]     enc_ecc,
    input  logic [SECDED_CODE_W-1:0] dec_code,
    output logic [SECDED_DATA_W-1:0] dec_data,
    output ecc_status_t              dec_status
);

    logic [ECC_WIDTH-1:0] syndrome;
    logic                 col_hit;
    logic                 chk_hit;

    assign enc_ecc  = secded_check(enc_data);
    assign syndrome = secded_check(dec_code[SECDED_DATA_W-1:0]) ^ dec_code[SECDED_CODE_W-1:SECDED_DATA_W];

    // Flip the data bit whose column matches the syndrome; classify the error.
    always_comb begin
        dec_data   = dec_code[SECDED_DATA_W-1:0];
        dec_status = '0;
        col_hit    = 1'b0;
        for (int i = 0; i < SECDED_DATA_W; i++) begin
            if (syndrome == H_COL[i]) begin
                dec_data[i] = ~dec_code[i];
                col_hit     = 1'b1;
            end
        end
        // A flipped check bit leaves the data intact but still counts as corrected.
        chk_hit             = $onehot(syndrome);
        dec_status.syndrome = syndrome;
        dec_status.sbe      = col_hit | chk_hit;
        dec_status.dbe      = (syndrome != '0) && !(col_hit | chk_hit);
    end

endmodule

// File: rtl/mci_mcu_sram_ctrl.sv
// Purpose: CIF target controller for the ECC-protected MCU SRAM (read, full write, RMW partial write).
// Latency: read 2 cycles, partial write 2 cycles, full/zero-strobe/out-of-range 1 cycle.
// Backpressure: req_hold stalls the requester, who keeps req_* stable until hold drops.
module mci_mcu_sram_ctrl
    import mci_sram_pkg::*;
#(
    parameter int  SRAM_SIZE_KB = 512,
    parameter int  ADDR_WIDTH   = 32,
    parameter int  DATA_WIDTH   = 32,
    parameter int  ECC_WIDTH    = 7,
    localparam int SRAM_AW      = $clog2(SRAM_SIZE_KB * 256)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_dv,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic                            req_write,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         req_wstrb,
    output logic                            req_hold,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic                            req_error,
    output logic                            sram_cs,
    output logic                            sram_we,
    output logic [SRAM_AW-1:0]              sram_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] sram_rdata,
    output logic                            ecc_sbe_pulse,
    output logic                            ecc_dbe_pulse,
    output logic [15:0]                     sbe_count,
    input  logic                            sbe_count_clr
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("mci_mcu_sram_ctrl: only DATA_WIDTH == 32 is supported");
    end
    if (ECC_WIDTH != mci_sram_pkg::ECC_WIDTH) begin : g_bad_ecc_width
        $error("mci_mcu_sram_ctrl: ECC_WIDTH must match the SECDED(39,32) code");
    end
    if ((SRAM_SIZE_KB <= 0) || ((SRAM_SIZE_KB & (SRAM_SIZE_KB - 1)) != 0)) begin : g_bad_size
        $error("mci_mcu_sram_ctrl: SRAM_SIZE_KB must be a power of two");
    end

    localparam logic [ADDR_WIDTH:0] SRAM_BYTES = (ADDR_WIDTH + 1)'(SRAM_SIZE_KB * 1024);

    ctrl_state_e           state;
    ctrl_state_e           next_state;

    logic                  in_range;
    logic [SRAM_AW-1:0]    word_idx;
    logic                  merge_sel;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ECC_WIDTH-1:0]  wr_ecc;

    logic [DATA_WIDTH-1:0] rd_data;
    ecc_status_t           rd_status;

    logic [DATA_WIDTH-1:0] wr_dec_data;
    ecc_status_t           wr_dec_status;
    logic [ECC_WIDTH-1:0]  rd_enc_ecc;
    logic                  unused_dec;

    // Offset is base-stripped already; anything at or past the macro size is an error.
    assign in_range = ({1'b0, req_addr} < SRAM_BYTES);
    assign word_idx = req_addr[SRAM_AW+1:2];

    // Write path: only the encoder half of this instance is used.
    mci_secded_39_32 u_wr_ecc (
        .enc_data   (wr_data),
        .enc_ecc    (wr_ecc),
        .dec_code   ('0),
        .dec_data   (wr_dec_data),
        .dec_status (wr_dec_status)
    );

    // Read path: only the decoder half of this instance is used.
    mci_secded_39_32 u_rd_ecc (
        .enc_data   ('0),
        .enc_ecc    (rd_enc_ecc),
        .dec_code   (sram_rdata),
        .dec_data   (rd_data),
        .dec_status (rd_status)
    );

    assign unused_dec = ^{wr_dec_data, wr_dec_status, rd_enc_ecc};

    // Byte merge for partial writes: strobed bytes from the request, the rest from the corrected old word.
    always_comb begin
        merged = rd_data;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (req_wstrb[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
        end
    end

    assign wr_data    = merge_sel ? merged : req_wdata;
    assign sram_wdata = sram_we ? {wr_ecc, wr_data} : '0;
    assign sram_addr  = sram_cs ? word_idx : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and request/SRAM outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        next_state    = state;
        req_hold      = 1'b0;
        req_rdata     = '0;
        req_error     = 1'b0;
        sram_cs       = 1'b0;
        sram_we       = 1'b0;
        merge_sel     = 1'b0;
        ecc_sbe_pulse = 1'b0;
        ecc_dbe_pulse = 1'b0;

        case (state)
            IDLE: begin
                if (req_dv) begin
                    if (!in_range) begin
                        req_error = 1'b1;
                    end else if (!req_write) begin
                        req_hold   = 1'b1;
                        sram_cs    = 1'b1;
                        next_state = RD_WAIT;
                    end else if (req_wstrb == '1) begin
                        sram_cs = 1'b1;
                        sram_we = 1'b1;
                    end else if (req_wstrb != '0) begin
                        req_hold   = 1'b1;
                        sram_cs    = 1'b1;
                        next_state = RMW_RD;
                    end
                end
            end

            RD_WAIT: begin
                next_state = IDLE;
                if (rd_status.dbe) begin
                    req_error     = 1'b1;
                    req_rdata     = sram_rdata[DATA_WIDTH-1:0];
                    ecc_dbe_pulse = 1'b1;
                end else begin
                    req_rdata     = rd_data;
                    ecc_sbe_pulse = rd_status.sbe;
                end
            end

            RMW_RD: begin
                next_state = IDLE;
                if (rd_status.dbe) begin
                    // Never write back a word we cannot trust.
                    req_error     = 1'b1;
                    ecc_dbe_pulse = 1'b1;
                end else begin
                    // Writing the corrected merge also scrubs a single-bit error.
                    sram_cs       = 1'b1;
                    sram_we       = 1'b1;
                    merge_sel     = 1'b1;
                    ecc_sbe_pulse = rd_status.sbe;
                end
            end

            RMW_WR: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        if (rst) begin
            next_state    = IDLE;
            req_hold      = 1'b0;
            req_rdata     = '0;
            req_error     = 1'b0;
            sram_cs       = 1'b0;
            sram_we       = 1'b0;
            merge_sel     = 1'b0;
            ecc_sbe_pulse = 1'b0;
            ecc_dbe_pulse = 1'b0;
        end
    end

    // Saturating corrected-error counter; a clear coinciding with an SBE leaves one count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sbe_count <= '0;
        end else if (sbe_count_clr) begin
            sbe_count <= ecc_sbe_pulse ? 16'd1 : 16'd0;
        end else if (ecc_sbe_pulse && (sbe_count != 16'hFFFF)) begin
            sbe_count <= sbe_count + 16'd1;
        end
    end

    // The requester must keep its request up until the controller releases hold.
    a_req_held: assert property (@(posedge clk) disable iff (rst) (state != IDLE) |-> req_dv);

endmodule

// File: tb/tb_mci_mcu_sram_ctrl.sv
// Purpose: directed self-checking bench for mci_mcu_sram_ctrl with a behavioural 1-cycle SRAM.
// Latency: n/a.
// Backpressure: the bench holds every request until req_hold is low.
module tb_mci_mcu_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_dv;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_hold;
    logic [31:0] req_rdata;
    logic        req_error;
    logic        sram_cs;
    logic        sram_we;
    logic [16:0] sram_addr;
    logic [38:0] sram_wdata;
    logic [38:0] sram_rdata = '0;
    logic        ecc_sbe_pulse;
    logic        ecc_dbe_pulse;
    logic [15:0] sbe_count;
    logic        sbe_count_clr;

    always #5 clk = ~clk;

    mci_mcu_sram_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_dv        (req_dv),
        .req_addr      (req_addr),
        .req_write     (req_write),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_hold      (req_hold),
        .req_rdata     (req_rdata),
        .req_error     (req_error),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .ecc_sbe_pulse (ecc_sbe_pulse),
        .ecc_dbe_pulse (ecc_dbe_pulse),
        .sbe_count     (sbe_count),
        .sbe_count_clr (sbe_count_clr)
    );

    // Behavioural SRAM macro with a backdoor load port and access counters.
    logic [38:0] mem [0:131071];
    logic        bd_we   = 1'b0;
    logic [16:0] bd_addr = '0;
    logic [38:0] bd_data = '0;
    int          cs_cnt  = 0;
    int          wr_cnt  = 0;
    logic [16:0] last_wa = '0;
    logic [38:0] last_wd = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (sram_cs) begin
            cs_cnt <= cs_cnt + 1;
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                wr_cnt         <= wr_cnt + 1;
                last_wa        <= sram_addr;
                last_wd        <= sram_wdata;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference check bits: the first 32 weight-3 7-bit vectors, enumerated by set-bit positions.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [6:0] c;
        int         n;
        c = '0;
        n = 0;
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++)
                for (int k = j + 1; k < 7; k++) begin
                    if (n < 32) begin
                        if (d[n]) c ^= 7'(1 << i) | 7'(1 << j) | 7'(1 << k);
                        n++;
                    end
                end
        return c;
    endfunction

    function automatic logic [38:0] ref_enc(input logic [31:0] d);
        return {ref_ecc(d), d};
    endfunction

    task automatic backdoor(input logic [16:0] idx, input logic [38:0] word);
        bd_we   = 1'b1;
        bd_addr = idx;
        bd_data = word;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    // Results of the last request.
    int          cyc;
    logic [31:0] o_rdata;
    logic        o_err, o_sbe, o_dbe;
    logic        f_cs, f_we;
    logic [16:0] f_addr;

    // Issue one request (called just after a rising edge) and hold it until completion.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb);
        logic done;
        req_dv    = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = strb;
        done      = 1'b0;
        cyc       = 0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                f_cs   = sram_cs;
                f_we   = sram_we;
                f_addr = sram_addr;
            end
            if (!req_hold) begin
                o_rdata = req_rdata;
                o_err   = req_error;
                o_sbe   = ecc_sbe_pulse;
                o_dbe   = ecc_dbe_pulse;
                done    = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_dv = 1'b0;
        if (!done) check("req_timeout", 64'(cyc), 64'd0);
    endtask

    int wr0, cs0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        sbe_count_clr = 1'b0;
        req_dv        = 1'b1;
        req_write     = 1'b1;
        req_addr      = 32'h0;
        req_wdata     = 32'hFFFF_FFFF;
        req_wstrb     = 4'hF;

        // Reset: a pending full write must not reach the SRAM.
        @(negedge clk);
        check("rst_cs", 64'(sram_cs), 64'd0);
        check("rst_we", 64'(sram_we), 64'd0);
        check("rst_hold_err", 64'({req_hold, req_error}), 64'd0);
        check("rst_wdata", 64'(sram_wdata), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        req_dv = 1'b0;
        @(negedge clk);
        check("rst_sbe_count", 64'(sbe_count), 64'd0);
        @(posedge clk); #1;

        // Read of word 4 via byte address 0x10.
        backdoor(17'd4, ref_enc(32'hDEAD_BEEF));
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        check("rd_cycles", 64'(cyc), 64'd2);
        check("rd_first_cs_we", 64'({f_cs, f_we}), 64'b10);
        check("rd_addr", 64'(f_addr), 64'd4);
        check("rd_data", 64'(o_rdata), 64'hDEAD_BEEF);
        check("rd_err", 64'({o_err, o_sbe, o_dbe}), 64'd0);

        // Full writes; the first two pin the check bits to hand-derived values.
        do_req(1'b1, 32'h0, 32'h0000_0001, 4'hF);
        check("enc_bit0", 64'(last_wd), 64'({7'h07, 32'h0000_0001}));
        do_req(1'b1, 32'h4, 32'h8000_0000, 4'hF);
        check("enc_bit31", 64'(last_wd), 64'({7'h38, 32'h8000_0000}));
        wr0 = wr_cnt;
        do_req(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        check("fw_cycles", 64'(cyc), 64'd1);
        check("fw_wrcnt", 64'(wr_cnt - wr0), 64'd1);
        check("fw_addr", 64'(last_wa), 64'd8);
        check("fw_wdata", 64'(last_wd), 64'(ref_enc(32'h1234_5678)));

        // Partial write: byte 1 replaced by read-modify-write.
        backdoor(17'd6, ref_enc(32'h1122_3344));
        wr0 = wr_cnt;
        do_req(1'b1, 32'h18, 32'h0000_AB00, 4'b0010);
        check("pw_cycles", 64'(cyc), 64'd2);
        check("pw_first_we", 64'({f_cs, f_we}), 64'b10);
        check("pw_wrcnt", 64'(wr_cnt - wr0), 64'd1);
        check("pw_addr", 64'(last_wa), 64'd6);
        check("pw_data", 64'(last_wd[31:0]), 64'h1122_AB44);
        check("pw_wdata", 64'(last_wd), 64'(ref_enc(32'h1122_AB44)));
        check("pw_err", 64'(o_err), 64'd0);

        // Single-bit error in a data bit, then in a check bit.
        backdoor(17'd7, ref_enc(32'hCAFE_F00D) ^ 39'(1 << 5));
        do_req(1'b0, 32'h1C, 32'h0, 4'h0);
        check("sbe_data", 64'(o_rdata), 64'hCAFE_F00D);
        check("sbe_flags", 64'({o_err, o_sbe, o_dbe}), 64'b010);
        check("sbe_count1", 64'(sbe_count), 64'd1);
        backdoor(17'd7, ref_enc(32'hCAFE_F00D) ^ (39'd1 << 33));
        do_req(1'b0, 32'h1C, 32'h0, 4'h0);
        check("sbe_chk_data", 64'(o_rdata), 64'hCAFE_F00D);
        check("sbe_count2", 64'(sbe_count), 64'd2);

        // Clear coinciding with an SBE leaves a count of one; a lone clear zeroes it.
        sbe_count_clr = 1'b1;
        do_req(1'b0, 32'h1C, 32'h0, 4'h0);
        sbe_count_clr = 1'b0;
        check("clr_with_sbe", 64'(sbe_count), 64'd1);
        sbe_count_clr = 1'b1;
        @(posedge clk); #1;
        sbe_count_clr = 1'b0;
        check("clr_alone", 64'(sbe_count), 64'd0);

        // Double-bit error (data bits 3 and 9): raw data back with error.
        backdoor(17'd9, ref_enc(32'h55AA_55AA) ^ 39'h208);
        do_req(1'b0, 32'h24, 32'h0, 4'h0);
        check("dbe_raw", 64'(o_rdata), 64'h55AA_57A2);
        check("dbe_flags", 64'({o_err, o_sbe, o_dbe}), 64'b101);
        check("dbe_no_count", 64'(sbe_count), 64'd0);
        wr0 = wr_cnt;
        do_req(1'b1, 32'h24, 32'h0000_00FF, 4'b0001);
        check("dbe_rmw_flags", 64'({o_err, o_dbe}), 64'b11);
        check("dbe_rmw_nowrite", 64'(wr_cnt - wr0), 64'd0);

        // Address boundary: last word is fine, first byte past the end is rejected.
        backdoor(17'h1FFFF, ref_enc(32'hA5A5_0F0F));
        do_req(1'b0, 32'h0007_FFFC, 32'h0, 4'h0);
        check("last_word", 64'({o_err, o_rdata}), 64'h0_A5A5_0F0F);
        cs0 = cs_cnt;
        do_req(1'b0, 32'h0008_0000, 32'h0, 4'h0);
        check("oor_rd", 64'({o_err, o_rdata}), 64'h1_0000_0000);
        check("oor_rd_cycles", 64'(cyc), 64'd1);
        do_req(1'b1, 32'hFFFF_FFF0, 32'h1, 4'hF);
        check("oor_wr_err", 64'(o_err), 64'd1);
        check("oor_no_cs", 64'(cs_cnt - cs0), 64'd0);

        // Zero-strobe write: immediate completion, no SRAM access.
        cs0 = cs_cnt;
        do_req(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0);
        check("zs_done", 64'({cyc[3:0], o_err}), 64'({4'd1, 1'b0}));
        check("zs_no_cs", 64'(cs_cnt - cs0), 64'd0);

        // Reset while the RMW read is outstanding drops the write.
        backdoor(17'd10, ref_enc(32'h0));
        req_dv    = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h28;
        req_wdata = 32'h0000_00FF;
        req_wstrb = 4'b0001;
        @(negedge clk);
        check("rrst_hold", 64'(req_hold), 64'd1);
        @(posedge clk); #1;
        wr0 = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rrst_quiet", 64'({req_hold, sram_cs, sram_we}), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        req_dv = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rrst_nowrite", 64'(wr_cnt - wr0), 64'd0);
        check("rrst_mem", 64'(mem[10]), 64'(ref_enc(32'h0)));

        // Controller is usable again after the reset.
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        check("post_rst_rd", 64'({o_err, o_rdata}), 64'h0_DEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
